data_memory_arbiter: RTL



---
 rtl/data_memory_arbiter_pkg.sv | 13 +
 rtl/data_memory_arbiter_rr_arbiter2.sv | 31 +++
 rtl/data_memory_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant between CPU and loader; load mode masks the CPU out.
module rr_arbiter2
  import data_memory_arbiter_pkg::*;
(
  input  logic load_mode,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_LDR;
    if (load_mode) begin
      grant_valid = ldr_req;
      grant_owner = OWNER_LDR;
    end else if (cpu_req && ldr_req) begin
      grant_valid = 1'b1;
      grant_owner = (last_grant == OWNER_LDR) ? OWNER_CPU : OWNER_LDR;
    end else if (cpu_req) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_CPU;
    end else if (ldr_req) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_LDR;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data RAM between the CPU data path and the UART loader.
// state  | meaning
// IDLE   | arbitrate, latch the winning request
// ISSUE  | drive the RAM for one cycle; writes are acked here
// RDWAIT | RAM read data returns; reads are acked here
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  iCpuClock,
  input  logic                  iCpuReset,
  input  logic                  iLoadMode,
  input  logic                  iCpuReq,
  input  logic                  iCpuWrite,
  input  logic [31:0]           iCpuAddr,
  input  logic [DATA_WIDTH-1:0] iCpuWData,
  output logic [DATA_WIDTH-1:0] oCpuRData,
  output logic                  oCpuAck,
  output logic                  oCpuStall,
  input  logic                  iLdrReq,
  input  logic                  iLdrWrite,
  input  logic [ADDR_WIDTH-1:0] iLdrAddr,
  input  logic [DATA_WIDTH-1:0] iLdrWData,
  output logic [DATA_WIDTH-1:0] oLdrRData,
  output logic                  oLdrAck,
  output logic                  oRamEn,
  output logic                  oRamWe,
  output logic [ADDR_WIDTH-1:0] oRamAddr,
  output logic [DATA_WIDTH-1:0] oRamWData,
  input  logic [DATA_WIDTH-1:0] iRamRData
);

  state_t                state, state_next;
  logic                  owner_q, write_q, last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cpu_ack_q, ldr_ack_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, ldr_rdata_q;
  logic                  grant_valid, grant_owner;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  unused_cpu_addr;

  assign unused_cpu_addr = ^{iCpuAddr[31:ADDR_WIDTH+2], iCpuAddr[1:0]};

  rr_arbiter2 u_rr_arbiter2 (
    .load_mode   (iLoadMode),
    .cpu_req     (iCpuReq),
    .ldr_req     (iLdrReq),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    sel_write = iCpuWrite;
    sel_addr  = iCpuAddr[ADDR_WIDTH+1:2];
    sel_wdata = iCpuWData;
    if (grant_owner == OWNER_LDR) begin
      sel_write = iLdrWrite;
      sel_addr  = iLdrAddr;
      sel_wdata = iLdrWData;
    end
  end

  always_comb begin
    state_next = state;
    oRamEn     = 1'b0;
    oRamWe     = 1'b0;
    oRamAddr   = '0;
    oRamWData  = '0;
    case (state)
      IDLE:   if (grant_valid) state_next = ISSUE;
      ISSUE: begin
        oRamEn     = 1'b1;
        oRamWe     = write_q;
        oRamAddr   = addr_q;
        oRamWData  = wdata_q;
        state_next = write_q ? IDLE : RDWAIT;
      end
      RDWAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCpuClock or negedge iCpuReset) begin
    if (!iCpuReset) begin
      state       <= IDLE;
      owner_q     <= OWNER_CPU;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_grant  <= OWNER_LDR;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state     <= state_next;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      if (state == IDLE && grant_valid) begin
        owner_q    <= grant_owner;
        write_q    <= sel_write;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        last_grant <= grant_owner;
        // Write acks are registered here so they appear during ISSUE.
        if (sel_write) begin
          cpu_ack_q <= (grant_owner == OWNER_CPU);
          ldr_ack_q <= (grant_owner == OWNER_LDR);
        end
      end
      if (state == ISSUE && !write_q) begin
        cpu_ack_q <= (owner_q == OWNER_CPU);
        ldr_ack_q <= (owner_q == OWNER_LDR);
      end
      if (state == RDWAIT) begin
        if (owner_q == OWNER_CPU) cpu_rdata_q <= iRamRData;
        else                      ldr_rdata_q <= iRamRData;
      end
    end
  end

  // RAM data arrives during RDWAIT; pass it through in the ack cycle, hold the register afterwards.
  assign oCpuRData = (state == RDWAIT && owner_q == OWNER_CPU) ? iRamRData : cpu_rdata_q;
  assign oLdrRData = (state == RDWAIT && owner_q == OWNER_LDR) ? iRamRData : ldr_rdata_q;
  assign oCpuAck   = cpu_ack_q;
  assign oLdrAck   = ldr_ack_q;
  assign oCpuStall = iCpuReq & ~cpu_ack_q;

endmodule
